// File: rtl/rgbw_frame_spi_master.sv
// SPI mode-0 transmitter for one 7-byte RGBW lamp frame, MSB first.
// Each frame holds cs low for CS_SETUP + 112*CLK_DIV + 6*BYTE_GAP + CS_HOLD cycles.
module rgbw_frame_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int BYTE_GAP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mode_in,
  input  logic [7:0] color_idx_in,
  input  logic [7:0] lint_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] white_in,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       cs,
  output logic       mosi
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (BYTE_GAP > CS_HOLD) ? BYTE_GAP : CS_HOLD;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [2:0]    byte_cnt, byte_nx;
  logic [54:0]   shreg, sh_nx;
  logic          busy_nx, done_nx, sck_nx, cs_nx, mosi_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_cnt  <= bit_nx;
      byte_cnt <= byte_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      sck      <= sck_nx;
      cs       <= cs_nx;
      mosi     <= mosi_nx;
    end
  end

  // Bits still to send after the one currently on mosi; data only, no reset.
  always_ff @(posedge clk) begin
    shreg <= sh_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    byte_nx  = byte_cnt;
    sh_nx    = shreg;
    busy_nx  = busy;
    done_nx  = 1'b0;
    sck_nx   = sck;
    cs_nx    = cs;
    mosi_nx  = mosi;
    case (state)
      IDLE: begin
        if (start) begin
          sh_nx    = {mode_in[6:0], color_idx_in, lint_in, red_in, green_in, blue_in, white_in};
          mosi_nx  = mode_in[7];
          cs_nx    = 1'b0;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          bit_nx   = '0;
          byte_nx  = '0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nx   = '0;
          state_nx = SHIFT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != DIV_LAST) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = '0;
          sck_nx = ~sck;
          // Falling edge ends a bit: the next bit goes out while sck is low.
          if (sck) begin
            if (bit_cnt == 3'd7) begin
              bit_nx = '0;
              if (byte_cnt == 3'd6) begin
                state_nx = HOLD;
              end else begin
                byte_nx = byte_cnt + 3'd1;
                mosi_nx = shreg[54];
                sh_nx   = {shreg[53:0], 1'b0};
                if (BYTE_GAP > 0) state_nx = GAP;
              end
            end else begin
              bit_nx  = bit_cnt + 3'd1;
              mosi_nx = shreg[54];
              sh_nx   = {shreg[53:0], 1'b0};
            end
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = SHIFT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = '0;
          cs_nx    = 1'b1;
          mosi_nx  = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rgbw_frame_spi_master.sv
// Bench for rgbw_frame_spi_master: default timing instance (a) and fastest timing instance (b)
// compared every cycle against a waveform model derived from frame position arithmetic.
module tb_rgbw_frame_spi_master;

  localparam int LA = 464;  // 2 + 7*16*4 + 6*2 + 2
  localparam int LB = 114;  // 1 + 7*16*1 + 0 + 1

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [7:0] mode_v = '0, color_v = '0, lint_v = '0, red_v = '0, green_v = '0, blue_v = '0, white_v = '0;
  logic busy_a, done_a, sck_a, cs_a, mosi_a;
  logic busy_b, done_b, sck_b, cs_b, mosi_b;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  bit act_a = 1'b0, act_b = 1'b0;
  int k_a = 0, k_b = 0, n_a = 0, n_b = 0;
  logic [55:0] fr_a = '0, fr_b = '0;
  logic [55:0] rx_a = '0, rx_b = '0;
  int rises_a = 0, rises_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0, busy_cnt_a = 0, done_cyc_a = 0, done_cyc_b = 0;

  rgbw_frame_spi_master dut_a (
    .clk(clk), .reset(rst_n), .start(start_a),
    .mode_in(mode_v), .color_idx_in(color_v), .lint_in(lint_v), .red_in(red_v),
    .green_in(green_v), .blue_in(blue_v), .white_in(white_v),
    .busy(busy_a), .done(done_a), .sck(sck_a), .cs(cs_a), .mosi(mosi_a)
  );

  rgbw_frame_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .BYTE_GAP(0), .CS_HOLD(1)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b),
    .mode_in(mode_v), .color_idx_in(color_v), .lint_in(lint_v), .red_in(red_v),
    .green_in(green_v), .blue_in(blue_v), .white_in(white_v),
    .busy(busy_b), .done(done_b), .sck(sck_b), .cs(cs_b), .mosi(mosi_b)
  );

  initial forever #5 clk = ~clk;

  // Expected {mosi_care, busy, done, cs, sck, mosi} k cycles after the accepting edge.
  function automatic logic [5:0] model(input int k, input logic [55:0] fr, input int cd,
                                       input int su, input int gp, input int hd);
    int len, per, u, byt, r, bt;
    logic s;
    len = su + 112*cd + 6*gp + hd;
    per = 16*cd + gp;
    u   = k - su;
    if (k >= len) return 6'b101100;
    if (k < su) return {5'b11000, fr[55]};
    if (u >= 112*cd + 6*gp) return 6'b010000;
    byt = u / per;
    r   = u % per;
    if (r >= 16*cd) return {5'b11000, fr[6'(55 - 8*(byt + 1))]};
    bt = r / (2*cd);
    s  = (r % (2*cd)) >= cd;
    return {4'b1100, s, fr[6'(55 - 8*byt - bt)]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string nm, input logic [4:0] act, input logic [5:0] exp);
    logic [4:0] mask;
    mask = exp[5] ? 5'h1f : 5'h1e;
    chk(nm, 64'(act & mask), 64'(exp[4:0] & mask));
  endtask

  task automatic set_inputs(input logic [55:0] fr);
    {mode_v, color_v, lint_v, red_v, green_v, blue_v, white_v} = fr;
  endtask

  function automatic logic [55:0] rnd56();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[55:0];
  endfunction

  task automatic wait_done(input bit on_b, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = on_b ? done_b : done_a;
    end
    chk(on_b ? "b_done_seen" : "a_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic send_a(input logic [55:0] fr, input bit scramble, input bit extra);
    int r0, d0, b0;
    @(posedge clk); #2;
    set_inputs(fr);
    start_a = 1'b1;
    r0 = rises_a; d0 = done_cnt_a; b0 = busy_cnt_a;
    @(posedge clk); #2;
    start_a = 1'b0;
    if (scramble) set_inputs(rnd56());
    if (extra) begin
      repeat (3) begin
        repeat ($urandom_range(20, 120)) @(posedge clk);
        #2 start_a = 1'b1;
        @(posedge clk); #2 start_a = 1'b0;
      end
    end
    wait_done(1'b0, 700);
    @(posedge clk); #1;
    chk("a_rx_bytes", 64'(rx_a), 64'(fr));
    chk("a_rises", 64'(rises_a - r0), 64'd56);
    chk("a_done_pulses", 64'(done_cnt_a - d0), 64'd1);
    chk("a_busy_cycles", 64'(busy_cnt_a - b0), 64'(LA));
    chk("a_latency", 64'(done_cyc_a - n_a), 64'(LA));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          act_a = 1'b0;
          act_b = 1'b0;
        end else begin
          cyc++;
          if ((!act_a || k_a == LA) && start_a) begin
            act_a = 1'b1; k_a = 0; n_a = cyc;
            fr_a = {mode_v, color_v, lint_v, red_v, green_v, blue_v, white_v};
          end else if (act_a && k_a == LA) act_a = 1'b0;
          else if (act_a) k_a++;
          if ((!act_b || k_b == LB) && start_b) begin
            act_b = 1'b1; k_b = 0; n_b = cyc;
            fr_b = {mode_v, color_v, lint_v, red_v, green_v, blue_v, white_v};
          end else if (act_b && k_b == LB) act_b = 1'b0;
          else if (act_b) k_b++;
        end
      end
      forever begin
        @(negedge clk);
        chk_out("a_cycle", {busy_a, done_a, cs_a, sck_a, mosi_a},
                act_a ? model(k_a, fr_a, 4, 2, 2, 2) : 6'b100100);
        chk_out("b_cycle", {busy_b, done_b, cs_b, sck_b, mosi_b},
                act_b ? model(k_b, fr_b, 1, 1, 0, 1) : 6'b100100);
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
        if (busy_a) busy_cnt_a++;
      end
      forever begin
        @(posedge sck_a);
        rx_a = {rx_a[54:0], mosi_a};
        rises_a++;
        chk("a_rise_cs_low", 64'(cs_a), 64'd0);
      end
      forever begin
        @(posedge sck_b);
        rx_b = {rx_b[54:0], mosi_b};
        rises_b++;
        chk("b_rise_cs_low", 64'(cs_b), 64'd0);
      end
    join_none

    repeat (2) @(posedge clk);
    #1 chk("a_reset_state", 64'({busy_a, done_a, cs_a, sck_a, mosi_a}), 64'h04);
    chk("b_reset_state", 64'({busy_b, done_b, cs_b, sck_b, mosi_b}), 64'h04);
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed frame, then frame with inputs changing after acceptance and ignored starts.
    send_a(56'h010203804020ff, 1'b0, 1'b0);
    send_a(56'h5a_c3_3c_a5_0f_f0_81, 1'b1, 1'b1);

    // Asynchronous reset 200 cycles into a frame.
    begin
      int d0;
      @(posedge clk); #2;
      set_inputs(rnd56());
      start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      d0 = done_cnt_a;
      repeat (199) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("a_async_reset_outputs", 64'({busy_a, done_a, cs_a, sck_a, mosi_a}), 64'h04);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (500) @(posedge clk);
      #1 chk("a_no_done_after_reset", 64'(done_cnt_a - d0), 64'd0);
    end
    send_a(rnd56(), 1'b1, 1'b0);

    // Fast instance: back-to-back frames with start in the done cycle.
    for (int f = 0; f < 3; f++) begin
      logic [55:0] f1, f2;
      int r0, n1;
      f1 = (f == 0) ? 56'h010203804020ff : rnd56();
      f2 = rnd56();
      @(posedge clk); #2;
      set_inputs(f1);
      start_b = 1'b1;
      r0 = rises_b;
      @(posedge clk); #2 start_b = 1'b0;
      set_inputs(rnd56());
      wait_done(1'b1, 300);
      n1 = n_b;
      set_inputs(f2);
      start_b = 1'b1;
      @(posedge clk); #2 start_b = 1'b0;
      @(negedge clk);
      chk("b_cs_high_one_cycle", 64'({cs_b, busy_b}), 64'h1);
      chk("b_latency", 64'(done_cyc_b - n1), 64'(LB));
      chk("b_rx_bytes", 64'(rx_b), 64'(f1));
      chk("b_rises", 64'(rises_b - r0), 64'd56);
      r0 = rises_b;
      wait_done(1'b1, 300);
      @(posedge clk); #1;
      chk("b_rx_bytes_2", 64'(rx_b), 64'(f2));
      chk("b_rises_2", 64'(rises_b - r0), 64'd56);
      chk("b_latency_2", 64'(done_cyc_b - n_b), 64'(LB));
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
